// File: rtl/sim_test_monitor_pkg.sv
// Shared definitions for the end-of-test monitor: the WFI encoding, FSM states
// and the helper that locates a hart's slice in the packed per-hart buses.
package sim_monitor_pkg;
  localparam logic [31:0] WFI_OPCODE = 32'h1050_0073;

  typedef enum logic [1:0] {RUN, FINISHED, TIMED_OUT} mon_state_e;

  function automatic int unsigned hart_lsb(input int unsigned h, input int unsigned xlen);
    return h * xlen;
  endfunction
endpackage

// File: rtl/sim_test_monitor_if.sv
// Bench-side bus of the monitor: per-hart trace inputs and the status it reports.
interface sim_test_monitor_if #(
  parameter int NUM_HARTS = 1,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32
);
  logic [NUM_HARTS*XLEN-1:0] instr;
  logic [NUM_HARTS*XLEN-1:0] a0;
  logic [NUM_HARTS-1:0]      hart_done;
  logic [NUM_HARTS*XLEN-1:0] hart_result;
  logic                      done;
  logic                      pass;
  logic                      timeout;
  logic [CNT_W-1:0]          cycle_count;

  modport master (output instr, a0,
                  input  hart_done, hart_result, done, pass, timeout, cycle_count);
  modport slave  (input  instr, a0,
                  output hart_done, hart_result, done, pass, timeout, cycle_count);
endinterface

// File: rtl/sim_test_monitor_wfi_detector.sv
// One hart: counts consecutive WFI samples, then latches a0 and a sticky done.
module hart_wfi_detector
  import sim_monitor_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] a0,
  output logic            done_o,
  output logic            done_d_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [7:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            is_wfi;

  assign is_wfi = (instr == XLEN'(WFI_OPCODE));

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    res_d  = res_q;
    // once finished (or the monitor has stopped) everything holds
    if (en && !done_q) begin
      if (!is_wfi) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        done_d = 1'b1;
        res_d  = a0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign done_o   = done_q;
  assign done_d_o = done_d;
  assign result_o = res_q;
endmodule

// File: rtl/sim_test_monitor.sv
// End-of-test monitor: per-hart WFI detectors, cycle counter, watchdog and
// the RUN/FINISHED/TIMED_OUT decision reported to the harness.
module sim_test_monitor
  import sim_monitor_pkg::*;
#(
  parameter int              NUM_HARTS      = 1,
  parameter int              XLEN           = 32,
  parameter int              STABLE_CYCLES  = 4,
  parameter longint unsigned PASS_CODE      = 0,
  parameter longint unsigned TIMEOUT_CYCLES = 1000000,
  parameter int              CNT_W          = 32
) (
  input logic               clk,
  input logic               reset,
  sim_test_monitor_if.slave bus
);
  localparam logic [XLEN-1:0]  PASS_X  = XLEN'(PASS_CODE);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             WDOG_EN = (TIMEOUT_CYCLES != 0);

  mon_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      to_q, to_d;
  logic [NUM_HARTS-1:0]      hart_done, hart_done_nxt;
  logic [NUM_HARTS*XLEN-1:0] hart_res;
  logic                      all_pass;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    hart_wfi_detector #(.XLEN(XLEN), .STABLE_CYCLES(STABLE_CYCLES)) u_det (
      .clk      (clk),
      .reset    (reset),
      .en       (state_q == RUN),
      .instr    (bus.instr[hart_lsb(h, XLEN) +: XLEN]),
      .a0       (bus.a0[hart_lsb(h, XLEN) +: XLEN]),
      .done_o   (hart_done[h]),
      .done_d_o (hart_done_nxt[h]),
      .result_o (hart_res[hart_lsb(h, XLEN) +: XLEN])
    );
  end

  always_comb begin
    all_pass = 1'b1;
    for (int h = 0; h < NUM_HARTS; h++)
      if (hart_res[h*XLEN +: XLEN] != PASS_X) all_pass = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    if (state_q == RUN) begin
      if (&hart_done) begin
        state_d = FINISHED;
        done_d  = 1'b1;
        pass_d  = all_pass;
      end else if (WDOG_EN && cnt_q == TO_LAST && !(&hart_done_nxt)) begin
        // a last hart completing on this very edge defers to FINISHED next cycle
        state_d = TIMED_OUT;
        to_d    = 1'b1;
        done_d  = 1'b1;
        pass_d  = 1'b0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign bus.hart_done   = hart_done;
  assign bus.hart_result = hart_res;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = to_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor: single-hart, four-hart and watchdog configs.
module tb_sim_test_monitor;
  import sim_monitor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ec;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (rst) ec <= 0; else ec <= ec + 1;

  sim_test_monitor_if #(.NUM_HARTS(1)) if1 ();
  sim_test_monitor_if #(.NUM_HARTS(4)) if4 ();
  sim_test_monitor_if #(.NUM_HARTS(1)) ift ();

  sim_test_monitor #(.NUM_HARTS(1), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(0))
    u1 (.clk(clk), .reset(rst), .bus(if1));
  sim_test_monitor #(.NUM_HARTS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(1000))
    u4 (.clk(clk), .reset(rst), .bus(if4));
  sim_test_monitor #(.NUM_HARTS(1), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100))
    ut (.clk(clk), .reset(rst), .bus(ift));

  typedef struct {
    string        tag;
    int           sel;
    logic [127:0] res;
    logic         pass;
    logic         to;
    int           at_ec;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic st_done(input int s);
    case (s)
      0:       return if1.done;
      1:       return if4.done;
      default: return ift.done;
    endcase
  endfunction

  function automatic logic [3:0] st_flags(input int s); // {pass, timeout}
    case (s)
      0:       return {2'b0, if1.pass, if1.timeout};
      1:       return {2'b0, if4.pass, if4.timeout};
      default: return {2'b0, ift.pass, ift.timeout};
    endcase
  endfunction

  function automatic logic [127:0] st_res(input int s);
    case (s)
      0:       return 128'(if1.hart_result);
      1:       return 128'(if4.hart_result);
      default: return 128'(ift.hart_result);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [127:0] res,
                      input logic pass, input logic to, input int at_ec);
    exp_t e;
    e.tag = tag; e.sel = sel; e.res = res; e.pass = pass; e.to = to; e.at_ec = at_ec;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int sel);
    exp_t e;
    int   n = 0;
    logic [3:0] f;
    while (!st_done(sel) && n < 300) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    f = st_flags(sel);
    chk({e.tag, "_done"},    128'(st_done(sel)), 128'(1));
    chk({e.tag, "_cycle"},   128'(ec),           128'(e.at_ec));
    chk({e.tag, "_pass"},    128'(f[1]),         128'(e.pass));
    chk({e.tag, "_timeout"}, 128'(f[0]),         128'(e.to));
    chk({e.tag, "_result"},  st_res(sel),        e.res);
  endtask

  task automatic wait_ec(input int n);
    while (ec < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if1.instr = '0; if1.a0 = '0;
    if4.instr = '0; if4.a0 = '0;
    ift.instr = '0; ift.a0 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_u1", {if1.hart_done, if1.hart_result, if1.done, if1.pass, if1.timeout, if1.cycle_count}, '0);
    chk("rst_u4", {if4.hart_done, if4.hart_result, if4.done, if4.pass, if4.timeout, if4.cycle_count}, '0);
    chk("rst_ut", {ift.hart_done, ift.hart_result, ift.done, ift.pass, ift.timeout, ift.cycle_count}, '0);
    rst = 1'b0;
  endtask

  initial begin
    int st[4];
    st = '{16, 31, 46, 86};

    // single hart, clean pass
    do_reset();
    push("s1", 0, 128'h0, 1'b1, 1'b0, 15);
    wait_ec(10);
    if1.instr = WFI_OPCODE;
    wait_ec(13);
    chk("s1_hd_early", 128'(if1.hart_done), 128'(0));
    wait_ec(14);
    chk("s1_hd", 128'(if1.hart_done), 128'(1));
    chk("s1_done_lag", 128'(if1.done), 128'(0));
    wait_done(0);
    if1.instr = '0;
    wait_ec(20);
    chk("s1_absorb", {if1.done, if1.pass}, 2'b11);

    // reset out of FINISHED, then a failing a0
    do_reset();
    if1.a0 = 32'h5;
    push("s2", 0, 128'h5, 1'b0, 1'b0, 7);
    wait_ec(2);
    if1.instr = WFI_OPCODE;
    wait_done(0);

    // glitch restarts the run counter; later a0/instr changes are ignored
    do_reset();
    if1.a0 = 32'h1234;
    push("s3", 0, 128'h1234, 1'b0, 1'b0, 11);
    wait_ec(2);  if1.instr = WFI_OPCODE;
    wait_ec(5);  if1.instr = 32'h13;
    wait_ec(6);  if1.instr = WFI_OPCODE;
    chk("s3_no_early", 128'(if1.hart_done), 128'(0));
    wait_ec(9);
    chk("s3_hd_9", 128'(if1.hart_done), 128'(0));
    wait_ec(10);
    chk("s3_hd_10", 128'(if1.hart_done), 128'(1));
    if1.a0 = 32'h9999;
    if1.instr = '0;
    wait_done(0);

    // four harts staggered; second run fails on hart 2
    for (int p = 0; p < 2; p++) begin
      do_reset();
      if (p == 1) if4.a0[64 +: 32] = 32'hDEAD;
      push(p == 0 ? "s4_pass" : "s4_fail", 1,
           p == 0 ? 128'h0 : (128'hDEAD << 64), (p == 0), 1'b0, 91);
      while (ec < 90) begin
        for (int h = 0; h < 4; h++)
          if (ec >= st[h]) if4.instr[h*32 +: 32] = WFI_OPCODE;
        if (ec == 50) chk("s4_partial", 128'(if4.hart_done), 128'(4'b0111));
        @(negedge clk);
      end
      wait_done(1);
    end

    // watchdog with no WFI
    do_reset();
    push("s5", 2, 128'h0, 1'b0, 1'b1, 100);
    wait_ec(99);
    chk("s5_pre_done", 128'(ift.done), 128'(0));
    chk("s5_pre_cnt", 128'(ift.cycle_count), 128'(99));
    wait_done(2);
    chk("s5_cnt_frozen", 128'(ift.cycle_count), 128'(99));
    wait_ec(110);
    chk("s5_cnt_hold", 128'(ift.cycle_count), 128'(99));
    chk("s5_wdog_off", 128'(if1.done), 128'(0));
    chk("s5_u1_cnt", 128'(if1.cycle_count), 128'(ec));

    // hart finishing on the watchdog edge wins
    do_reset();
    push("s6", 2, 128'h0, 1'b1, 1'b0, 101);
    wait_ec(96);
    ift.instr = WFI_OPCODE;
    wait_ec(100);
    chk("s6_hd", 128'(ift.hart_done), 128'(1));
    chk("s6_no_to", 128'(ift.timeout), 128'(0));
    wait_done(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
